hazard_tracker: RTL and testbench

Pipeline tag tracker that sits directly upstream of the hazard unit in the pipelined ARM core. It carries register-number tags and write-control bits for the Execute, Memory and Writeback stages, honouring flushes. From these it produces every match and pending-write signal the hazard unit consumes: Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E, RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF and PCSrcW. Optional performance counters tally stall cycles and taken branches.

---
 rtl/hazard_tracker.sv | 175 +++++++++++++++++
 tb/tb_hazard_tracker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hazard_tracker
// Purpose  : Carries register tags and write-control bits through the
//            Execute, Memory and Writeback stages of the pipelined ARM core
//            and produces the raw match and pending-write signals consumed
//            by the hazard unit. Optional saturating performance counters
//            tally stall cycles and taken branches.
// Config   : HAZARD_PERF_CNT_EN - when defined, adds stall_cnt/branch_cnt
//            ports and their counter logic.
// Ports    :
//   clk, reset                      clock, asynchronous active-low reset
//   RA1D, RA2D, WA3D                Decode source/destination tags
//   RegWriteD, MemtoRegD, PCSrcD    Decode control bits
//   CondExE                         Execute condition passed
//   FlushE                          bubble the Execute register
//   StallD, BranchTakenE, perf_clr  counter events / clear
//   Match_1E_M .. Match_12D_E       raw 4-bit tag compares
//   RegWriteM, RegWriteW            Memory / Writeback write enables
//   MemtoRegE                       Execute instruction is a load
//   PCWrPendingF, PCSrcW            PC write in flight / in Writeback
//   stall_cnt, branch_cnt           performance counters (macro only)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_tracker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             CondExE,
    input  logic             FlushE,
    input  logic             StallD,
    input  logic             BranchTakenE,
    input  logic             perf_clr,
    output logic             Match_1E_M,
    output logic             Match_1E_W,
    output logic             Match_2E_M,
    output logic             Match_2E_W,
    output logic             Match_12D_E,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic             MemtoRegE,
    output logic             PCWrPendingF,
    output logic             PCSrcW
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] branch_cnt
`endif
);

    // Execute stage
    logic [3:0] r_ra1E;
    logic [3:0] r_ra2E;
    logic [3:0] r_wa3E;
    logic       r_regWriteE;
    logic       r_memtoRegE;
    logic       r_pcSrcE;

    // Memory stage
    logic [3:0] r_wa3M;
    logic       r_regWriteM;
    logic       r_memtoRegM;
    logic       r_pcSrcM;

    // Writeback stage
    logic [3:0] r_wa3W;
    logic       r_regWriteW;
    logic       r_pcSrcW;

    // Execute register: a flush inserts an all-zero bubble (tags included).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ra1E      <= 4'd0;
            r_ra2E      <= 4'd0;
            r_wa3E      <= 4'd0;
            r_regWriteE <= 1'b0;
            r_memtoRegE <= 1'b0;
            r_pcSrcE    <= 1'b0;
        end else if (FlushE) begin
            r_ra1E      <= 4'd0;
            r_ra2E      <= 4'd0;
            r_wa3E      <= 4'd0;
            r_regWriteE <= 1'b0;
            r_memtoRegE <= 1'b0;
            r_pcSrcE    <= 1'b0;
        end else begin
            r_ra1E      <= RA1D;
            r_ra2E      <= RA2D;
            r_wa3E      <= WA3D;
            r_regWriteE <= RegWriteD;
            r_memtoRegE <= MemtoRegD;
            r_pcSrcE    <= PCSrcD;
        end
    end

    // Memory and Writeback registers never stall or flush. Controls leaving
    // Execute are gated by the condition check; the tag always propagates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wa3M      <= 4'd0;
            r_regWriteM <= 1'b0;
            r_memtoRegM <= 1'b0;
            r_pcSrcM    <= 1'b0;
            r_wa3W      <= 4'd0;
            r_regWriteW <= 1'b0;
            r_pcSrcW    <= 1'b0;
        end else begin
            r_wa3M      <= r_wa3E;
            r_regWriteM <= r_regWriteE & CondExE;
            r_memtoRegM <= r_memtoRegE & CondExE;
            r_pcSrcM    <= r_pcSrcE & CondExE;
            r_wa3W      <= r_wa3M;
            r_regWriteW <= r_regWriteM;
            r_pcSrcW    <= r_pcSrcM;
        end
    end

    // Raw tag compares; RegWrite/MemtoReg qualification lives in the hazard unit.
    assign Match_1E_M   = (r_ra1E == r_wa3M);
    assign Match_1E_W   = (r_ra1E == r_wa3W);
    assign Match_2E_M   = (r_ra2E == r_wa3M);
    assign Match_2E_W   = (r_ra2E == r_wa3W);
    assign Match_12D_E  = (RA1D == r_wa3E) | (RA2D == r_wa3E);

    assign RegWriteM    = r_regWriteM;
    assign RegWriteW    = r_regWriteW;
    assign MemtoRegE    = r_memtoRegE;
    assign PCWrPendingF = PCSrcD | r_pcSrcE | r_pcSrcM;
    assign PCSrcW       = r_pcSrcW;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_cntMax = '1;

    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_branchCnt;

    // Clear wins over increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt  <= '0;
            r_branchCnt <= '0;
        end else if (perf_clr) begin
            r_stallCnt  <= '0;
            r_branchCnt <= '0;
        end else begin
            if (StallD && (r_stallCnt != c_cntMax)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (BranchTakenE && (r_branchCnt != c_cntMax)) begin
                r_branchCnt <= r_branchCnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stallCnt;
    assign branch_cnt = r_branchCnt;

    // MemtoRegM is kept for pipeline completeness but has no consumer here.
    logic w_unused;
    assign w_unused = r_memtoRegM;
`else
    // Counter inputs and MemtoRegM have no consumer in this build.
    logic w_unused;
    assign w_unused = ^{r_memtoRegM, StallD, BranchTakenE, perf_clr, (CNT_W > 0)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_tracker
// Purpose  : Self-checking bench for hazard_tracker. A history-based model
//            derives the contents of each stage from the Decode inputs
//            applied one, two and three cycles earlier and checks every
//            output each cycle; directed sequences pin literal values.
// Config   : HAZARD_PERF_CNT_EN - also checks the counters (CNT_W = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_tracker;

    localparam int CNT_W  = 2;
    localparam int MAXCYC = 1024;

    typedef struct packed {
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa3;
        logic       rw;
        logic       mr;
        logic       pcs;
    } instr_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic [3:0] RA1D = '0, RA2D = '0, WA3D = '0;
    logic RegWriteD = 0, MemtoRegD = 0, PCSrcD = 0;
    logic CondExE = 0, FlushE = 0, StallD = 0, BranchTakenE = 0, perfClr = 0;
    logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt, branchCnt;
`endif

    always #5 clk = ~clk;

    hazard_tracker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rstN),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
        .CondExE(CondExE), .FlushE(FlushE), .StallD(StallD),
        .BranchTakenE(BranchTakenE), .perf_clr(perfClr),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .Match_12D_E(Match_12D_E),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stallCnt), .branch_cnt(branchCnt)
`endif
    );

    // Per-cycle history of what was applied to the DUT.
    instr_t dHist  [MAXCYC];
    logic   flHist [MAXCYC];
    logic   cdHist [MAXCYC];
    logic   rlHist [MAXCYC];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    int     stallModel = 0;
    int     branchModel = 0;
    int     cntMax = (1 << CNT_W) - 1;

    // The instruction sitting in a stage at cycle t is the Decode input of
    // an earlier cycle, unless a reset or flush intervened on the way.
    function automatic instr_t eAt(int t);
        if (t == 0 || rlHist[t] || rlHist[t-1] || flHist[t-1]) return '0;
        return dHist[t-1];
    endfunction

    function automatic instr_t mAt(int t);
        instr_t s;
        if (t == 0 || rlHist[t] || rlHist[t-1]) return '0;
        s = eAt(t-1);
        s.rw  = s.rw  & cdHist[t-1];
        s.mr  = s.mr  & cdHist[t-1];
        s.pcs = s.pcs & cdHist[t-1];
        return s;
    endfunction

    function automatic instr_t wAt(int t);
        if (t == 0 || rlHist[t] || rlHist[t-1]) return '0;
        return mAt(t-1);
    endfunction

    function automatic instr_t mk(int ra1, int ra2, int wa3, bit rw, bit mr, bit pcs);
        instr_t x;
        x.ra1 = 4'(ra1); x.ra2 = 4'(ra2); x.wa3 = 4'(wa3);
        x.rw = rw; x.mr = mr; x.pcs = pcs;
        return x;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic checkModel(input int t);
        instr_t d, e, m, w;
        d = dHist[t]; e = eAt(t); m = mAt(t); w = wAt(t);
        cmp("Match_1E_M",   int'(Match_1E_M),   int'(e.ra1 == m.wa3));
        cmp("Match_1E_W",   int'(Match_1E_W),   int'(e.ra1 == w.wa3));
        cmp("Match_2E_M",   int'(Match_2E_M),   int'(e.ra2 == m.wa3));
        cmp("Match_2E_W",   int'(Match_2E_W),   int'(e.ra2 == w.wa3));
        cmp("Match_12D_E",  int'(Match_12D_E),  int'((d.ra1 == e.wa3) || (d.ra2 == e.wa3)));
        cmp("RegWriteM",    int'(RegWriteM),    int'(m.rw));
        cmp("RegWriteW",    int'(RegWriteW),    int'(w.rw));
        cmp("MemtoRegE",    int'(MemtoRegE),    int'(e.mr));
        cmp("PCWrPendingF", int'(PCWrPendingF), int'(d.pcs | e.pcs | m.pcs));
        cmp("PCSrcW",       int'(PCSrcW),       int'(w.pcs));
`ifdef HAZARD_PERF_CNT_EN
        cmp("stall_cnt",    int'(stallCnt),     stallModel);
        cmp("branch_cnt",   int'(branchCnt),    branchModel);
`endif
    endtask

    // One cycle: drive just after the rising edge, check on the falling edge.
    task automatic step(input instr_t x, input bit fl, input bit cd, input bit rl,
                        input bit st, input bit br, input bit clr);
        @(posedge clk);
        #1;
        RA1D = x.ra1; RA2D = x.ra2; WA3D = x.wa3;
        RegWriteD = x.rw; MemtoRegD = x.mr; PCSrcD = x.pcs;
        FlushE = fl; CondExE = cd; StallD = st; BranchTakenE = br; perfClr = clr;
        rstN = ~rl;
        dHist[cyc] = x; flHist[cyc] = fl; cdHist[cyc] = cd; rlHist[cyc] = rl;
        if (rl) begin
            stallModel = 0;
            branchModel = 0;
        end
        @(negedge clk);
        checkModel(cyc);
        if (!rl) begin
            if (clr) begin
                stallModel = 0;
                branchModel = 0;
            end else begin
                if (st && stallModel < cntMax) stallModel++;
                if (br && branchModel < cntMax) branchModel++;
            end
        end
        cyc++;
    endtask

    initial begin
        instr_t z;
        z = '0;

        // Reset: outputs pinned to literal reset values.
        step(z, 0, 0, 1, 0, 0, 0);
        step(mk(2, 5, 0, 0, 0, 1), 0, 0, 1, 0, 0, 0);
        cmp("rst_RegWriteM", int'(RegWriteM), 0);
        cmp("rst_Match_1E_M", int'(Match_1E_M), 1);
        cmp("rst_Match_12D_E", int'(Match_12D_E), 0);
        cmp("rst_PCWrPendingF", int'(PCWrPendingF), 1);
        cmp("rst_PCSrcW", int'(PCSrcW), 0);
        step(z, 0, 0, 0, 0, 0, 0);
        cmp("rel_RegWriteM", int'(RegWriteM), 0);
        cmp("rel_PCWrPendingF", int'(PCWrPendingF), 0);
        cmp("rel_Match_1E_M", int'(Match_1E_M), 1);
        cmp("rel_Match_12D_E", int'(Match_12D_E), 1);

        // Load r3 followed by a reader of r3.
        step(mk(0, 0, 3, 1, 1, 0), 0, 1, 0, 0, 0, 0);
        step(mk(3, 0, 7, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        cmp("load_Match_12D_E", int'(Match_12D_E), 1);
        cmp("load_MemtoRegE", int'(MemtoRegE), 1);
        step(z, 0, 1, 0, 0, 0, 0);

        // Write r5 (condition passes), readers on RA2.
        step(mk(1, 2, 5, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(4, 5, 9, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(6, 5, 10, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        cmp("wr_Match_2E_M", int'(Match_2E_M), 1);
        cmp("wr_RegWriteM", int'(RegWriteM), 1);
        step(mk(0, 0, 11, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        cmp("wr_Match_2E_W", int'(Match_2E_W), 1);
        cmp("wr_RegWriteW", int'(RegWriteW), 1);

        // Same write with the condition failing: tags still travel.
        step(mk(1, 2, 5, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(4, 5, 9, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        step(mk(6, 5, 10, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        cmp("nc_Match_2E_M", int'(Match_2E_M), 1);
        cmp("nc_RegWriteM", int'(RegWriteM), 0);
        step(mk(0, 0, 11, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        cmp("nc_Match_2E_W", int'(Match_2E_W), 1);
        cmp("nc_RegWriteW", int'(RegWriteW), 0);

        // PC write travels three cycles pending, then appears in Writeback.
        step(mk(0, 0, 0, 0, 0, 1), 0, 1, 0, 0, 0, 0);
        cmp("pc_pend0", int'(PCWrPendingF), 1);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("pc_pend1", int'(PCWrPendingF), 1);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("pc_pend2", int'(PCWrPendingF), 1);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("pc_pend3", int'(PCWrPendingF), 0);
        cmp("pc_PCSrcW", int'(PCSrcW), 1);

        // Same PC write flushed on its way into Execute.
        step(mk(0, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0, 0);
        cmp("fl_pend0", int'(PCWrPendingF), 1);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("fl_pend1", int'(PCWrPendingF), 0);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("fl_pend2", int'(PCWrPendingF), 0);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("fl_PCSrcW", int'(PCSrcW), 0);

`ifdef HAZARD_PERF_CNT_EN
        // Saturation at 3 after five stall cycles; clear beats increment.
        step(z, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(z, 0, 1, 0, 1, 0, 0);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("cnt_stall_sat", int'(stallCnt), 3);
        step(z, 0, 1, 0, 0, 1, 0);
        step(z, 0, 1, 0, 0, 1, 1);
        step(z, 0, 1, 0, 0, 0, 0);
        cmp("cnt_branch_clr", int'(branchCnt), 0);
`endif

        // Random traffic with small tag range, flushes, failed conditions
        // and occasional mid-run resets.
        for (int i = 0; i < 500; i++) begin
            instr_t x;
            bit rl;
            x.ra1 = 4'($urandom_range(0, 5));
            x.ra2 = 4'($urandom_range(0, 5));
            x.wa3 = 4'($urandom_range(0, 5));
            x.rw  = 1'($urandom_range(0, 1));
            x.mr  = 1'($urandom_range(0, 1));
            x.pcs = ($urandom_range(0, 4) == 0);
            rl    = ($urandom_range(0, 59) == 0);
            step(x, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7), rl,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
